gpio_ascii_receiver: RTL and testbench

GPIO_ASCII_RECEIVER -- requirements
Module: gpio_ascii_receiver

---
 rtl/gpio_ascii_receiver.sv | 185 ++++++++++++++++++
 tb/tb_gpio_ascii_receiver.sv | 220 ++++++++++++++++++++++
 2 files changed

// File: rtl/gpio_ascii_receiver.sv
// gpio_ascii_receiver
//   Takes ASCII characters from a MicroBlaze GPIO output word using a
//   toggle request/ack handshake, queues them in a FIFO, and presents
//   the FIFO head to a downstream consumer.
//
// Handshake rules:
//   - GPIO side: software writes byte [7:0] and inverts bit [8] in a single
//     write. A request is pending while the registered bit [8] differs from
//     ack. Ack (status[0]) follows bit [8] once the byte has been written.
//   - Consumer side: char_out/char_valid follow strict valid/ready rules.
//     A character is consumed on a clock edge where char_valid and
//     char_ready are both 1. char_out stays stable while char_valid is 1
//     and char_ready is 0.
//
// Ports:
//   clk           100 MHz clock, shared with the GPIO.
//   reset_rtl_0   asynchronous, active-low reset.
//   gpio_tx_word  [7:0] byte, [8] request toggle, [9] flush level.
//   gpio_status   [0] ack, [1] full, [2] empty, [3] protocol_err (sticky),
//                 [4] busy (WAIT_SPACE), [10:5] occupancy,
//                 [10+COUNT_W:11] accepted count.
//   char_out      head-of-FIFO character (registered).
//   char_valid    char_out holds a valid character (registered).
//   char_ready    the consumer accepts char_out.
module gpio_ascii_receiver #(
  parameter int DEPTH   = 16,
  parameter int COUNT_W = 12
) (
  input  logic        clk,
  input  logic        reset_rtl_0,
  input  logic [31:0] gpio_tx_word,
  output logic [31:0] gpio_status,
  output logic [7:0]  char_out,
  output logic        char_valid,
  input  logic        char_ready
);

  localparam int AW = $clog2(DEPTH);
  localparam int OW = AW + 1;

  typedef enum logic {IDLE, WAIT_SPACE} state_t;

  state_t             state_q, state_d;
  logic               req_q, req_d;
  logic               ack_q, ack_d;
  logic               perr_q, perr_d;
  logic [7:0]         hold_q, hold_d;
  logic [COUNT_W-1:0] count_q, count_d;
  logic [OW-1:0]      occ_q, occ_d;
  logic [AW-1:0]      rd_q, rd_d;
  logic [AW-1:0]      wr_q, wr_d;
  logic [7:0]         char_out_q, char_out_d;
  logic               char_valid_q, char_valid_d;
  logic [7:0]         mem_q [DEPTH];

  logic          flush, full, empty, push, pop;
  logic [7:0]    push_data;
  logic [OW-1:0] occ_after_pop;

  assign flush = gpio_tx_word[9];
  assign full  = (occ_q == OW'(DEPTH));
  assign empty = (occ_q == '0);

  always_comb begin
    state_d       = state_q;
    req_d         = gpio_tx_word[8];
    ack_d         = ack_q;
    perr_d        = perr_q;
    hold_d        = hold_q;
    count_d       = count_q;
    occ_d         = occ_q;
    rd_d          = rd_q;
    wr_d          = wr_q;
    char_out_d    = char_out_q;
    char_valid_d  = char_valid_q;
    push          = 1'b0;
    pop           = 1'b0;
    push_data     = gpio_tx_word[7:0];
    occ_after_pop = occ_q;

    if (flush) begin
      // Flush wins over everything; ack tracks the live toggle so a pending
      // request completes without a write.
      state_d      = IDLE;
      ack_d        = gpio_tx_word[8];
      perr_d       = 1'b0;
      hold_d       = 8'h00;
      occ_d        = '0;
      rd_d         = '0;
      wr_d         = '0;
      char_valid_d = 1'b0;
    end else begin
      pop = char_valid_q && char_ready;

      // Full is sampled before any same-cycle pop, so a request that meets
      // a full FIFO always defers to WAIT_SPACE.
      case (state_q)
        IDLE: begin
          if (req_q != ack_q) begin
            if (!full) begin
              push    = 1'b1;
              ack_d   = req_q;
              count_d = count_q + COUNT_W'(1);
            end else begin
              hold_d  = gpio_tx_word[7:0];
              state_d = WAIT_SPACE;
            end
          end
        end
        WAIT_SPACE: begin
          // The toggle returning to ack while waiting means software issued
          // a second request. Completing with ack = req_q discards it.
          if (req_q == ack_q) perr_d = 1'b1;
          if (!full) begin
            push      = 1'b1;
            push_data = hold_q;
            ack_d     = req_q;
            count_d   = count_q + COUNT_W'(1);
            state_d   = IDLE;
          end
        end
        default: state_d = IDLE;
      endcase

      if (pop)  rd_d = rd_q + AW'(1);
      if (push) wr_d = wr_q + AW'(1);
      occ_after_pop = occ_q - OW'(pop);
      occ_d         = occ_after_pop + OW'(push);

      // Registered head: a byte written into an otherwise empty FIFO
      // becomes the head directly; otherwise read the new head slot.
      char_valid_d = (occ_d != '0);
      if (push && (occ_after_pop == '0)) char_out_d = push_data;
      else if (occ_after_pop != '0)      char_out_d = mem_q[rd_d];
    end
  end

  always_ff @(posedge clk or negedge reset_rtl_0) begin
    if (!reset_rtl_0) begin
      state_q      <= IDLE;
      req_q        <= 1'b0;
      ack_q        <= 1'b0;
      perr_q       <= 1'b0;
      hold_q       <= 8'h00;
      count_q      <= '0;
      occ_q        <= '0;
      rd_q         <= '0;
      wr_q         <= '0;
      char_out_q   <= 8'h00;
      char_valid_q <= 1'b0;
    end else begin
      state_q      <= state_d;
      req_q        <= req_d;
      ack_q        <= ack_d;
      perr_q       <= perr_d;
      hold_q       <= hold_d;
      count_q      <= count_d;
      occ_q        <= occ_d;
      rd_q         <= rd_d;
      wr_q         <= wr_d;
      char_out_q   <= char_out_d;
      char_valid_q <= char_valid_d;
    end
  end

  // Storage needs no reset; the occupancy and pointers qualify it.
  always_ff @(posedge clk) begin
    if (push) mem_q[wr_q] <= push_data;
  end

  always_comb begin
    gpio_status                 = '0;
    gpio_status[0]              = ack_q;
    gpio_status[1]              = full;
    gpio_status[2]              = empty;
    gpio_status[3]              = perr_q;
    gpio_status[4]              = (state_q == WAIT_SPACE);
    gpio_status[10:5]           = 6'(occ_q);
    gpio_status[10+COUNT_W:11]  = count_q;
  end

  assign char_out   = char_out_q;
  assign char_valid = char_valid_q;

endmodule

// File: tb/tb_gpio_ascii_receiver.sv
// Testbench for gpio_ascii_receiver: directed sequence with random bytes,
// reference model = ordered queue of expected characters plus an
// accepted-character counter.
module tb_gpio_ascii_receiver;

  logic        clk;
  logic        rst_n;
  logic [31:0] tx_word;
  logic [31:0] status;
  logic [7:0]  char_out;
  logic        char_valid;
  logic        char_ready;

  int total = 0;
  int bad   = 0;

  logic [7:0]  exp_q[$];
  logic [11:0] cnt_model;
  int          max_occ;

  gpio_ascii_receiver #(.DEPTH(16), .COUNT_W(12)) dut (
    .clk          (clk),
    .reset_rtl_0  (rst_n),
    .gpio_tx_word (tx_word),
    .gpio_status  (status),
    .char_out     (char_out),
    .char_valid   (char_valid),
    .char_ready   (char_ready)
  );

  // ---------------- clock / reset ----------------
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  // ---------------- checking ----------------
  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Consumer-side scoreboard: every character handed over must be the
  // oldest expected one.
  always @(negedge clk) begin
    if (rst_n && !tx_word[9] && char_valid && char_ready) begin
      check("char_expected", 32'(exp_q.size() != 0), 32'd1);
      if (exp_q.size() != 0) check("char_order", 32'(char_out), 32'(exp_q.pop_front()));
    end
  end

  // ---------------- driver tasks ----------------
  task automatic tick();
    @(posedge clk);
    #1;
    if (int'(status[10:5]) > max_occ) max_occ = int'(status[10:5]);
  endtask

  task automatic send(input logic [7:0] b, input bit wait_ack, input bit expected);
    bit got;
    tx_word[7:0] = b;
    tx_word[8]   = ~tx_word[8];
    if (expected) begin
      exp_q.push_back(b);
      cnt_model++;
    end
    if (wait_ack) begin
      got = 1'b0;
      for (int i = 0; i < 10 && !got; i++) begin
        tick();
        if (status[0] == tx_word[8]) got = 1'b1;
      end
      check("ack_wait", 32'(got), 32'd1);
    end
  endtask

  task automatic drain();
    bit done;
    done = 1'b0;
    char_ready = 1'b1;
    for (int i = 0; i < 80 && !done; i++) begin
      tick();
      if (status[2] && !char_valid && !status[4]) done = 1'b1;
    end
    char_ready = 1'b0;
    check("drain_done", 32'(done), 32'd1);
    check("drain_all_seen", 32'(exp_q.size()), 32'd0);
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    logic       ack_before;
    logic [7:0] x;
    logic [11:0] cnt_save;

    rst_n      = 1'b0;
    tx_word    = 32'h0;
    char_ready = 1'b0;
    cnt_model  = '0;
    max_occ    = 0;
    #2;
    check("reset_status", status, 32'h0000_0004);
    check("reset_char_out", 32'(char_out), 32'h0);
    check("reset_char_valid", 32'(char_valid), 32'h0);
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    // Single character with latency check.
    tx_word = 32'h0000_0141;
    exp_q.push_back(8'h41);
    cnt_model++;
    tick();
    check("single_ack_not_yet", 32'(status[0]), 32'd0);
    tick();
    check("single_ack", 32'(status[0]), 32'd1);
    check("single_valid", 32'(char_valid), 32'd1);
    check("single_char", 32'(char_out), 32'h41);
    check("single_count", 32'(status[22:11]), 32'(cnt_model));
    drain();

    // Fill to full with 'a'..'p', then a 17th request that must wait.
    for (int i = 0; i < 16; i++) send(8'h61 + 8'(i), 1'b1, 1'b1);
    check("fill_full", 32'(status[1]), 32'd1);
    check("fill_occ", 32'(status[10:5]), 32'd16);
    check("fill_head", 32'(char_out), 32'h61);
    ack_before = status[0];
    send(8'h71, 1'b0, 1'b1);
    repeat (3) tick();
    check("wait_busy", 32'(status[4]), 32'd1);
    check("wait_ack_held", 32'(status[0]), 32'(ack_before));
    char_ready = 1'b1;
    tick();
    char_ready = 1'b0;
    check("pop_still_busy", 32'(status[4]), 32'd1);
    check("pop_occ", 32'(status[10:5]), 32'd15);
    tick();
    check("deferred_busy_clear", 32'(status[4]), 32'd0);
    check("deferred_ack", 32'(status[0]), 32'(tx_word[8]));
    check("deferred_count", 32'(status[22:11]), 32'(cnt_model));
    check("deferred_occ", 32'(status[10:5]), 32'd16);
    drain();

    // Streaming with the consumer always ready.
    char_ready = 1'b1;
    max_occ = 0;
    for (int i = 0; i < 40; i++) send(8'($urandom_range(32, 126)), 1'b1, 1'b1);
    check("stream_occ_max", 32'(max_occ <= 1), 32'd1);
    check("stream_count", 32'(status[22:11]), 32'(cnt_model));
    drain();

    // Protocol error: second toggle while waiting for space.
    for (int i = 0; i < 16; i++) send(8'($urandom_range(32, 126)), 1'b1, 1'b1);
    send(8'($urandom_range(32, 126)), 1'b0, 1'b1);
    repeat (2) tick();
    check("perr_busy", 32'(status[4]), 32'd1);
    send(8'($urandom_range(32, 126)), 1'b0, 1'b0);
    repeat (3) tick();
    check("perr_set", 32'(status[3]), 32'd1);
    check("perr_still_busy", 32'(status[4]), 32'd1);
    drain();
    check("perr_sticky", 32'(status[3]), 32'd1);
    check("perr_count", 32'(status[22:11]), 32'(cnt_model));
    check("perr_no_pending", 32'(status[0]), 32'(tx_word[8]));

    // Flush with five characters queued.
    for (int i = 0; i < 5; i++) send(8'($urandom_range(32, 126)), 1'b1, 1'b1);
    check("flush_pre_busy", 32'(status[4]), 32'd0);
    check("flush_pre_occ", 32'(status[10:5]), 32'd5);
    cnt_save = status[22:11];
    tx_word[9] = 1'b1;
    tick();
    tx_word[9] = 1'b0;
    exp_q.delete();
    check("flush_empty", 32'(status[2]), 32'd1);
    check("flush_occ", 32'(status[10:5]), 32'd0);
    check("flush_valid", 32'(char_valid), 32'd0);
    check("flush_perr_clear", 32'(status[3]), 32'd0);
    check("flush_count_kept", 32'(status[22:11]), 32'(cnt_save));
    send(8'h5A, 1'b1, 1'b1);
    check("post_flush_char", 32'(char_out), 32'h5A);
    drain();
    check("post_flush_count", 32'(status[22:11]), 32'(cnt_model));

    // Reset while waiting for space with a full FIFO.
    for (int i = 0; i < 16; i++) send(8'($urandom_range(32, 126)), 1'b1, 1'b1);
    x = 8'($urandom_range(32, 126));
    send(x, 1'b0, 1'b1);
    repeat (2) tick();
    check("rst_pre_busy", 32'(status[4]), 32'd1);
    rst_n = 1'b0;
    #1;
    check("rst_async_status", status, 32'h0000_0004);
    check("rst_async_char_out", 32'(char_out), 32'h0);
    check("rst_async_valid", 32'(char_valid), 32'h0);
    exp_q.delete();
    cnt_model = '0;
    repeat (2) tick();
    rst_n = 1'b1;
    if (tx_word[8]) begin
      exp_q.push_back(x);
      cnt_model++;
    end
    repeat (3) tick();
    check("rst_rerequest_ack", 32'(status[0]), 32'(tx_word[8]));
    check("rst_rerequest_count", 32'(status[22:11]), 32'(cnt_model));
    drain();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
